// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier for the MUL/IMUL path.
// One add-and-shift step per clock through a WIDTH-bit ripple-carry chain;
// the double-width product and the CF/OF flag are registered when the
// operation completes.
// Optional feature: define SIGNED_MUL_EN to add the Signed input (IMUL).
// Operands are then loaded as magnitudes, and a FIX cycle negates the product
// when the operand signs differ.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
`ifdef SIGNED_MUL_EN
  input  logic                 Signed,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 CF
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [CW-1:0]        cnt;
  logic                 sign_x;     // operand signs differ: product needs negating
  logic                 signed_op;  // operation in flight is IMUL

  logic                 signed_req;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH-1:0]   prod_step;
  logic [2*WIDTH-1:0]   prod_neg;
  logic                 last_iter;

`ifdef SIGNED_MUL_EN
  assign signed_req = Signed;
`else
  assign signed_req = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Unsigned overflow: any bit set in the high word.
  function automatic logic cf_unsigned(input logic [2*WIDTH-1:0] p);
    return |p[2*WIDTH-1:WIDTH];
  endfunction

  // Signed overflow: high word is not the sign extension of the low word.
  function automatic logic cf_signed(input logic [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
  endfunction

  // Operand magnitudes for IMUL; plain operands for MUL.
  assign mag_a = (signed_req && A[WIDTH-1]) ? negate(A) : A;
  assign mag_b = (signed_req && B[WIDTH-1]) ? negate(B) : B;

  // Ripple-carry chain of full-adder cells: high word of PROD + MCAND.
  // NOTE: every variable written here gets a value before any conditional
  // use, so the block stays purely combinational and no latch is inferred.
  always_comb begin
    logic c;
    c       = 1'b0;
    add_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = mcand[i] ^ prod[WIDTH+i] ^ c;
      c          = (mcand[i] & prod[WIDTH+i]) | (c & (mcand[i] ^ prod[WIDTH+i]));
    end
    add_cout = c;
  end

  // Next PROD value for one iteration: add-and-shift or shift only.
  always_comb begin
    if (prod[0]) prod_step = {add_cout, add_sum, prod[WIDTH-1:1]};
    else         prod_step = {1'b0, prod[2*WIDTH-1:1]};
  end

  assign prod_neg  = ~prod + (2*WIDTH)'(1);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Control FSM with datapath and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      sign_x    <= 1'b0;
      signed_op <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Product   <= '0;
      CF        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          Done <= 1'b0;
          if (Start) begin
            mcand     <= mag_a;
            prod      <= {{WIDTH{1'b0}}, mag_b};
            cnt       <= '0;
            sign_x    <= signed_req & (A[WIDTH-1] ^ B[WIDTH-1]);
            signed_op <= signed_req;
            Busy      <= 1'b1;
            state     <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          prod <= prod_step;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            if (sign_x) begin
              state <= S_FIX;
            end else begin
              Product <= prod_step;
              CF      <= signed_op ? cf_signed(prod_step) : cf_unsigned(prod_step);
              Busy    <= 1'b0;
              Done    <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_FIX: begin
          prod    <= prod_neg;
          Product <= prod_neg;
          CF      <= cf_signed(prod_neg);
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=16) using a result scoreboard.
module tb_seq_multiplier;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] product;
    logic           cf;
    int             latency;
  } exp_t;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           Start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
`ifdef SIGNED_MUL_EN
  logic           Signed = 1'b0;
`endif
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Product;
  logic           CF;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .A       (A),
    .B       (B),
`ifdef SIGNED_MUL_EN
    .Signed  (Signed),
`endif
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product),
    .CF      (CF)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn);
    exp_t                  e;
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb_v;
    if (sgn) begin
      sa        = $signed(a);
      sb_v      = $signed(b);
      e.product = sa * sb_v;
      e.cf      = e.product[2*W-1:W] != {W{e.product[W-1]}};
      e.latency = W + 1 + ((a[W-1] ^ b[W-1]) ? 1 : 0);
    end else begin
      e.product = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.cf      = |e.product[2*W-1:W];
      e.latency = W + 1;
    end
    return e;
  endfunction

  // Called on a negedge: request accepted on the next posedge, returns on
  // the following negedge (cycle 1 of the operation) with A/B scrambled.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sgn);
    Start = 1'b1;
    A     = a;
    B     = b;
`ifdef SIGNED_MUL_EN
    Signed = sgn;
`endif
    sb.push_back(model(a, b, sgn));
    @(negedge Clk);
    Start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
`ifdef SIGNED_MUL_EN
    Signed = 1'b0;
`endif
  endtask

  // Waits for Done starting at operation cycle n0, then pops and compares.
  task automatic wait_done(input string name, input int n0);
    int   n       = n0;
    logic busy_ok = 1'b1;
    exp_t e;
    while (!Done && n < 60) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      @(negedge Clk);
      n++;
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: no Done after %0d cycles, required Done=1", name, n);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (n !== e.latency) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, n, e.latency);
    end
    checks++;
    if (Product !== e.product) begin
      errors++;
      $display("FAIL %s_product: got %h, required %h", name, Product, e.product);
    end
    checks++;
    if (CF !== e.cf) begin
      errors++;
      $display("FAIL %s_cf: got %b, required %b", name, CF, e.cf);
    end
    checks++;
    if (busy_ok !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy_ok=%b busy_at_done=%b, required 1/0", name, busy_ok, Busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if ({Busy, Done, CF, Product} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b cf=%b product=%h, required all 0",
               Busy, Done, CF, Product);
    end
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] held;
    drive_start(16'h00FF, 16'h0101, 1'b0);
    wait_done("basic", 1);
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b one cycle after Done, required 0", Done);
    end
    held = Product;
    repeat (3) @(negedge Clk);
    checks++;
    if (Product !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL hold_idle: got %h, required %h", Product, 32'h0000FFFF);
    end
    drive_start(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done("max", 1);
    @(negedge Clk);
    drive_start(16'h1234, 16'h0000, 1'b0);
    wait_done("zero", 1);
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      drive_start(W'($urandom), W'($urandom), 1'b0);
      wait_done("random", 1);
      @(negedge Clk);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(16'd3, 16'd5, 1'b0);
    repeat (3) @(negedge Clk);
    Start = 1'b1;
    A     = 16'd7;
    B     = 16'd7;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("ignored_start", 5);
    drive_start(16'd2, 16'd2, 1'b0);
    wait_done("back_to_back", 1);
    @(negedge Clk);
  endtask

  task automatic test_async_reset();
    drive_start(16'hFFFF, 16'h0002, 1'b0);
    repeat (7) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({Busy, Done, CF, Product} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b cf=%b product=%h, required all 0",
               Busy, Done, CF, Product);
    end
    sb.delete();
    @(negedge Clk);
    Rst = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (25) begin
        @(negedge Clk);
        if (Done !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: activity seen after reset, required none");
      end
    end
  endtask

`ifdef SIGNED_MUL_EN
  task automatic test_signed();
    drive_start(16'hFFFE, 16'h0003, 1'b1);
    wait_done("signed_neg", 1);
    @(negedge Clk);
    drive_start(16'h8000, 16'h8000, 1'b1);
    wait_done("signed_min", 1);
    @(negedge Clk);
    drive_start(16'hFFFE, 16'h0003, 1'b0);
    wait_done("signed_off", 1);
    @(negedge Clk);
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_async_reset();
`ifdef SIGNED_MUL_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier for the 8086 MUL/IMUL path.
- Sits directly upstream of the ripple-carry adder chain built from full_adder cells. Each cycle it presents multiplicand and partial-product operands to that adder and registers the Sum/Cout it returns.
- Produces a double-width product (DX:AX / AH:AL style) plus the CF/OF flag value for the flags stage.

Parameters:
- WIDTH, 16, operand width in bits; legal values 8 and 16; product is 2*WIDTH bits.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; accepted only in IDLE or DONE.
- A  input  WIDTH  multiplicand, sampled on the accepting edge.
- B  input  WIDTH  multiplier, sampled on the accepting edge.
- Busy  output  1  high while an operation is in progress (LOAD/RUN/FIX).
- Done  output  1  one-cycle pulse: Product and CF valid.
- Product  output  2*WIDTH  result; upper half = high word.
- CF  output  1  carry/overflow flag; OF carries the same value.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, Busy=0, Done=0, Product=0, CF=0, iteration counter=0, internal operand registers=0.
- States: IDLE, RUN, FIX (only with SIGNED_MUL_EN), DONE.
- IDLE/DONE + Start=1 on edge k: latch A into MCAND; load PROD = {WIDTH zeros, B}; counter=0; go to RUN. Busy=1 from cycle k+1.
- RUN, each edge:
  - If PROD[0]=1: upper half + MCAND through the WIDTH-bit adder chain. The WIDTH+1-bit result {Cout, Sum} is shifted right one place into PROD.
  - If PROD[0]=0: PROD shifts right one place with 0 entering the MSB.
  - counter increments.
  - After the WIDTH-th iteration (edge k+WIDTH), go to DONE (or FIX when required).
- DONE: Done=1 for exactly one cycle. Busy=0. Product register updated on entry to DONE. Next state is IDLE, unless Start=1 in DONE (back-to-back accepted, Done still pulses that cycle).
- Unsigned latency: Start edge k, Done high in cycle k+WIDTH+1 (17 cycles for WIDTH=16). Throughput is one operation per WIDTH+1 cycles.
- Product and CF hold their last values in IDLE until the next operation reaches DONE.
- Start while Busy=1: ignored; no effect on the operation in flight.
- A/B changes after the accepting edge: no effect.
- CF (unsigned) = 1 iff Product upper half != 0.
- Zero operand: still runs the full WIDTH iterations; Product=0, CF=0.
- No combinational path from Start/A/B to any output; all outputs are registered.

Optional Feature:
- Macro SIGNED_MUL_EN.
- Defined:
  - Adds input port Signed (1 bit), sampled with Start.
  - If Signed=1, A and B are loaded as magnitudes (two's-complement negation via the adder when MSB=1); the sign XOR is stored.
  - After RUN, if sign XOR=1, the FIX state negates the 2*WIDTH product (one extra cycle). If sign XOR=0, FIX is skipped.
  - Signed CF = 1 iff the upper half is not the sign extension of the lower half's MSB.
  - Signed=0 behaves exactly as the unsigned case.
  - Most-negative operand (0x8000) is handled correctly: its magnitude 0x8000 fits unsigned.
- Undefined: no Signed port, no FIX state, unsigned only; the FIX encoding may be omitted.

Test Plan:
- WIDTH=16, reset, then Start with A=0x00FF, B=0x0101 -> Done in cycle 17 after the Start edge, Product=0x0000FFFF, CF=0, Busy high for cycles 1..16.
- A=0xFFFF, B=0xFFFF -> Product=0xFFFE0001, CF=1.
- A=0x1234, B=0x0000 -> Product=0x00000000, CF=0; latency is still 17 cycles.
- Start A=3, B=5; pulse Start with A=7, B=7 at cycle 5 -> second request ignored, Product=0x0000000F; then Start in the DONE cycle with A=2, B=2 -> Product=0x00000004 after a further 17 cycles.
- Start A=0xFFFF, B=0x0002; assert Rst at cycle 8 -> Busy=0, Done=0, Product=0 immediately (async); no Done pulse until a new Start.
- SIGNED_MUL_EN, Signed=1:
  - A=0xFFFE (-2), B=0x0003 -> Product=0xFFFFFFFA, CF=0, Done at cycle 18.
  - A=0x8000, B=0x8000 -> Product=0x40000000, CF=1.
